// File: rtl/mem_master_if.sv
// mem_master_if: request/response and memory-bus signals of mem_master.
//   req_*  : client request (valid/ready handshake, write flag, address, data,
//            and req_len only when MEM_MASTER_BURST_EN is defined)
//   rsp_*  : per-beat response pulse, read data, last-beat marker
//   mem_*  : single-port memory bus (address, enable, read_write, data out/in)
// Modport master is the mem_master side, slave is the client + memory side.
interface mem_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
`ifdef MEM_MASTER_BURST_EN
    logic [ADDR_W-1:0] req_len;
`endif
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic [ADDR_W-1:0] mem_address_bus;
    logic              mem_enable;
    logic              mem_read_write;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;

    modport master (
`ifdef MEM_MASTER_BURST_EN
        input  req_len,
`endif
        input  req_valid, req_write, req_addr, req_wdata, mem_data_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_last,
        output mem_address_bus, mem_enable, mem_read_write, mem_data_out
    );

    modport slave (
`ifdef MEM_MASTER_BURST_EN
        output req_len,
`endif
        output req_valid, req_write, req_addr, req_wdata, mem_data_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last,
        input  mem_address_bus, mem_enable, mem_read_write, mem_data_out
    );
endinterface

// File: rtl/mem_master.sv
// mem_master: turns client requests into single-port memory accesses.
// Each beat is ISSUE (one-cycle mem_enable strobe) -> CAPTURE (reads only,
// memory data registered at its end) -> RESP (one-cycle rsp_valid pulse).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_master_if.master (request, response and memory bus)
// Optional feature: define MEM_MASTER_BURST_EN to add req_len; a request then
// runs req_len+1 beats at consecutive (wrapping) addresses, writes repeating
// the same data. Without it every request is exactly one beat.
module mem_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    mem_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state, state_nxt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              last_beat;

`ifdef MEM_MASTER_BURST_EN
    logic [ADDR_W-1:0] beats_left;  // beats remaining after the current one
    assign last_beat = (beats_left == '0);
`else
    assign last_beat = 1'b1;
`endif

    // The address register only moves on accept or on advancing to the next
    // beat, so the bus naturally holds the last driven address otherwise.
    assign bus.mem_address_bus = addr_q;
    assign bus.rsp_rdata       = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.req_ready      = 1'b0;
        bus.mem_enable     = 1'b0;
        bus.mem_read_write = 1'b1;
        bus.mem_data_out   = '0;
        bus.rsp_valid      = 1'b0;
        bus.rsp_last       = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mem_enable     = 1'b1;
                bus.mem_read_write = ~write_q;
                if (write_q) bus.mem_data_out = wdata_q;
                state_nxt = write_q ? RESP : CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = last_beat;
                state_nxt     = last_beat ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef MEM_MASTER_BURST_EN
            beats_left <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    write_q    <= bus.req_write;
                    addr_q     <= bus.req_addr;
                    wdata_q    <= bus.req_wdata;
`ifdef MEM_MASTER_BURST_EN
                    beats_left <= bus.req_len;
`endif
                end
                // Write beats report zero data; load it before RESP.
                ISSUE:   if (write_q) rdata_q <= '0;
                CAPTURE: rdata_q <= bus.mem_data_in;
                RESP: if (!last_beat) begin
                    addr_q     <= addr_q + ADDR_W'(1);  // wraps at 2^ADDR_W
`ifdef MEM_MASTER_BURST_EN
                    beats_left <= beats_left - ADDR_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed bench for mem_master. A transaction-level model
// schedules, at each accepted request, what every beat must show on the
// memory bus and response port (cycle numbers and values); a negedge process
// compares the DUT against that schedule every cycle. Directed tasks add
// literal latency/data expectations. Burst cases run with MEM_MASTER_BURST_EN.
module tb_mem_master;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_master #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_end = -1;
    int en_count = 0;
    logic prev_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory attached to the bus: synchronous, read data valid the cycle after ISSUE.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) begin
        mem[i] = DW'(i * 17);
        ref_mem[i] = DW'(i * 17);
    end
    always @(posedge clk) begin
        if (bus.mem_enable) begin
            if (bus.mem_read_write) bus.mem_data_in <= mem[bus.mem_address_bus];
            else mem[bus.mem_address_bus] = bus.mem_data_out;
        end
    end

    // Model: cycle-indexed schedule of memory accesses and responses.
    typedef struct packed {logic rw; logic [AW-1:0] addr; logic [DW-1:0] dout;} iss_t;
    typedef struct packed {logic last; logic [DW-1:0] rdata;} rsp_t;
    iss_t iss_q[int];
    rsp_t rsp_q[int];
    logic [AW-1:0] held_addr = '0;
    logic [DW-1:0] held_rdata = '0;

    task automatic model_accept(input logic w, input logic [AW-1:0] a0,
                                input logic [DW-1:0] wd, input int n);
        int t;
        logic [AW-1:0] a;
        t = cyc;
        a = a0;
        for (int b = 0; b < n; b++) begin
            iss_q[t] = '{rw: ~w, addr: a, dout: (w ? wd : '0)};
            if (w) begin
                ref_mem[a] = wd;
                rsp_q[t+1] = '{last: (b == n-1), rdata: '0};
                t += 2;
            end else begin
                rsp_q[t+2] = '{last: (b == n-1), rdata: ref_mem[a]};
                t += 3;
            end
            a = a + 1'b1;
        end
        busy_end = t - 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n && bus.req_valid && (cyc - 1) > busy_end) begin
`ifdef MEM_MASTER_BURST_EN
            model_accept(bus.req_write, bus.req_addr, bus.req_wdata, int'(bus.req_len) + 1);
`else
            model_accept(bus.req_write, bus.req_addr, bus.req_wdata, 1);
`endif
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_en", bus.mem_enable, 0);
            chk("rst_rw", bus.mem_read_write, 1);
            chk("rst_addr", bus.mem_address_bus, 0);
            chk("rst_dout", bus.mem_data_out, 0);
            chk("rst_rv", bus.rsp_valid, 0);
            chk("rst_last", bus.rsp_last, 0);
            chk("rst_rdata", bus.rsp_rdata, 0);
            iss_q.delete();
            rsp_q.delete();
            busy_end = -1;
            held_addr = '0;
            held_rdata = '0;
        end else begin
            if (iss_q.exists(cyc)) begin
                held_addr = iss_q[cyc].addr;
                chk("mem_enable", bus.mem_enable, 1);
                chk("mem_read_write", bus.mem_read_write, iss_q[cyc].rw);
                chk("mem_data_out", bus.mem_data_out, iss_q[cyc].dout);
            end else begin
                chk("mem_enable", bus.mem_enable, 0);
                chk("mem_read_write", bus.mem_read_write, 1);
                chk("mem_data_out", bus.mem_data_out, 0);
            end
            chk("mem_address_bus", bus.mem_address_bus, held_addr);
            if (rsp_q.exists(cyc)) begin
                held_rdata = rsp_q[cyc].rdata;
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_last", bus.rsp_last, rsp_q[cyc].last);
            end else begin
                chk("rsp_valid", bus.rsp_valid, 0);
                chk("rsp_last", bus.rsp_last, 0);
            end
            chk("rsp_rdata", bus.rsp_rdata, held_rdata);
            chk("req_ready", bus.req_ready, (cyc > busy_end));
        end
        chk("en_back_to_back", prev_en & bus.mem_enable, 0);
        prev_en = bus.mem_enable;
        if (bus.mem_enable) en_count++;
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 50 && !bus.req_ready; k++) @(negedge clk);
        chk("ready_timeout", (k >= 50), 0);
    endtask

    task automatic drive_req(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [AW-1:0] len);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
`ifdef MEM_MASTER_BURST_EN
        bus.req_len   = len;
`else
        if (len != '0) $display("note: req_len ignored in single-beat build");
`endif
    endtask

    // One request; returns latency of first response, beat count, last rdata.
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] len, output int lat, output int beats,
                       output logic [DW-1:0] rd);
        int k;
        lat = 0; beats = 0; rd = '0;
        @(negedge clk);
        wait_ready();
        drive_req(w, a, d, len);
        @(posedge clk);
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                if (beats == 0) lat = k;
                beats++;
                rd = bus.rsp_rdata;
                if (bus.rsp_last) break;
            end
        end
        chk("rsp_timeout", (k > 100), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    int lat, beats, en0;
    logic [DW-1:0] rd;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef MEM_MASTER_BURST_EN
        bus.req_len   = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_rw", bus.mem_read_write, 1);
        #2 rst_n = 1'b1;

        // Write 3 <- A5, then read it back.
        txn(1'b1, 4'd3, 8'hA5, '0, lat, beats, rd);
        chk("wr_latency", lat, 2);
        chk("wr_beats", beats, 1);
        chk("wr_rdata", rd, 8'h00);
        txn(1'b0, 4'd3, 8'h00, '0, lat, beats, rd);
        chk("rd_latency", lat, 3);
        chk("rd_rdata", rd, 8'hA5);
        txn(1'b0, 4'd5, 8'h00, '0, lat, beats, rd);
        chk("rd5_rdata", rd, 8'h55);
        txn(1'b1, 4'd15, 8'h5A, '0, lat, beats, rd);
        txn(1'b0, 4'd15, 8'h00, '0, lat, beats, rd);
        chk("rd15_rdata", rd, 8'h5A);
        txn(1'b0, 4'd9, 8'h00, '0, lat, beats, rd);
        chk("rd9_rdata", rd, 8'h99);

        // req_valid held while busy: 12 edges give exactly 3 accesses.
        @(negedge clk);
        wait_ready();
        en0 = en_count;
        drive_req(1'b0, 4'd7, 8'h00, '0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("hold_accesses", en_count - en0, 3);

        // Reset during CAPTURE of a read.
        @(negedge clk);
        wait_ready();
        drive_req(1'b0, 4'd3, 8'h00, '0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", bus.mem_enable, 0);
        chk("midrst_rv", bus.rsp_valid, 0);
        chk("midrst_ready", bus.req_ready, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        txn(1'b0, 4'd3, 8'h00, '0, lat, beats, rd);
        chk("postrst_latency", lat, 3);
        chk("postrst_rdata", rd, 8'hA5);

`ifdef MEM_MASTER_BURST_EN
        txn(1'b0, 4'd14, 8'h00, 4'd3, lat, beats, rd);
        chk("brd_beats", beats, 4);
        chk("brd_latency", lat, 3);
        chk("brd_last_rdata", rd, 8'h11);
        txn(1'b1, 4'd0, 8'h3C, 4'd15, lat, beats, rd);
        chk("bwr_beats", beats, 16);
        chk("bwr_latency", lat, 2);
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, AW'(i), 8'h00, '0, lat, beats, rd);
            chk("fill_rdata", rd, 8'h3C);
        end
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
